i2c_target: RTL and testbench

//  I2C target (slave) endpoint, counterpart to the team's I2C master.
//  - Oversamples SCL/SDA on a local system clock; clk must run at >= 8x the SCL rate.
//  - Responds to one 7-bit address. Accepts 1- or 2-byte writes and serves 1- or 2-byte reads, MSB first.
//  - Sits behind the pad/open-drain logic. Exposes a parallel data interface to the local register file.

---
 rtl/i2c_target_pkg.sv | 23 ++
 rtl/i2c_target_bus_monitor.sv | 46 ++++
 rtl/i2c_target.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_target_pkg;

  // Target protocol states.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAckA,
    StRx,
    StAckRx,
    StTx,
    StAckTx,
    StWaitStop
  } state_e;

  // Open-drain SDA drive levels.
  localparam logic DriveLow = 1'b0;
  localparam logic Release  = 1'b1;

  // Write bytes accepted per transaction; later bytes are NACKed.
  localparam logic [1:0] MaxRxBytes = 2'd2;

endpackage

// File: rtl/i2c_target_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and decodes bus edges and conditions.
module i2c_target_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;

  // Synchroniser chains plus one history flop; reset to the idle (released) bus level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda   = sda_sync_q[SYNC_STAGES-1];

  // SDA edges only count as START/STOP while SCL is stably high.
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & ~sda & sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q & sda & ~sda_hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: one 7-bit address, 1-2 byte writes into rx_data, 1-2 byte reads from tx_data.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        scl_out,
  input  logic [15:0] tx_data,
  input  logic        tx_two_bytes,
  output logic [15:0] rx_data,
  output logic        rx_two_bytes,
  output logic        rx_valid,
  output logic        rd_done,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_target_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_buf_q, tx_buf_d;
  logic        tx_two_q, tx_two_d;
  logic        tx_pend_q, tx_pend_d;
  logic        is_wr_q, is_wr_d;
  logic        sda_q, sda_d;
  logic        busy_q, busy_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_two_q, rx_two_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rd_done_q, rd_done_d;

  logic [7:0]  rx_byte;
  logic [7:0]  tx_first;

  assign rx_byte  = {shift_q[6:0], sda_s};
  assign tx_first = tx_two_q ? tx_buf_q[15:8] : tx_buf_q[7:0];

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_two_q   <= 1'b0;
      tx_pend_q  <= 1'b0;
      is_wr_q    <= 1'b0;
      sda_q      <= Release;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_two_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_two_q   <= tx_two_d;
      tx_pend_q  <= tx_pend_d;
      is_wr_q    <= is_wr_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_two_q   <= rx_two_d;
      rx_valid_q <= rx_valid_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_two_d   = tx_two_q;
    tx_pend_d  = tx_pend_q;
    is_wr_d    = is_wr_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_two_d   = rx_two_q;
    rx_valid_d = 1'b0;
    rd_done_d  = 1'b0;

    if (start_det) begin
      // Also a repeated START: the previous transaction is dropped without rx_valid.
      state_d    = StAddr;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      is_wr_d    = 1'b0;
      sda_d      = Release;
      busy_d     = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      sda_d   = Release;
      busy_d  = 1'b0;
      is_wr_d = 1'b0;
      if (is_wr_q && (byte_cnt_q != 2'd0)) begin
        rx_valid_d = 1'b1;
        rx_two_d   = (byte_cnt_q == MaxRxBytes);
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if ((bit_cnt_q == 4'd7) && (shift_q[6:0] != TARGET_ADDR)) begin
              state_d = StWaitStop;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            state_d  = StAckA;
            sda_d    = DriveLow;
            busy_d   = 1'b1;
            is_wr_d  = ~shift_q[0];
            tx_buf_d = tx_data;
            tx_two_d = tx_two_bytes;
          end
        end
        StAckA: begin
          if (scl_fall) begin
            if (is_wr_q) begin
              state_d   = StRx;
              sda_d     = Release;
              bit_cnt_d = '0;
            end else begin
              // First read bit goes out on the same fall that ends the address ACK.
              state_d    = StTx;
              sda_d      = tx_first[7];
              tx_shift_d = {tx_first[6:0], 1'b0};
              tx_pend_d  = tx_two_q;
              bit_cnt_d  = 4'd1;
            end
          end
        end
        StRx: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (byte_cnt_q < MaxRxBytes) begin
                rx_data_d  = {rx_data_q[7:0], rx_byte};
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = StAckRx;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StAckRx: begin
          // bit_cnt tracks the ACK phase: 0 = drive low next fall, 1 = release next fall.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_d     = DriveLow;
              bit_cnt_d = 4'd1;
            end else begin
              sda_d     = Release;
              bit_cnt_d = '0;
              state_d   = StRx;
            end
          end
        end
        StTx: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_d   = Release;
              state_d = StAckTx;
            end else begin
              sda_d      = tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        StAckTx: begin
          if (scl_rise) begin
            if (!sda_s && tx_pend_q) begin
              tx_shift_d = tx_buf_q[7:0];
              tx_pend_d  = 1'b0;
              bit_cnt_d  = '0;
              state_d    = StTx;
            end else begin
              rd_done_d = 1'b1;
              state_d   = StWaitStop;
            end
          end
        end
        StWaitStop: sda_d = Release;
        default:    state_d = StIdle;
      endcase
    end
  end

  assign sda_out      = sda_q;
  assign scl_out      = 1'b1;
  assign rx_data      = rx_data_q;
  assign rx_two_bytes = rx_two_q;
  assign rx_valid     = rx_valid_q;
  assign rd_done      = rd_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench: timed I2C master model, reference model and scoreboard monitor.
module tb_i2c_target;

  localparam logic [6:0] Addr = 7'h42;

  typedef struct {
    bit          is_write;
    logic [15:0] data;
    bit          two;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m, sda_m;
  logic        sda_out, scl_out;
  logic [15:0] tx_data;
  logic        tx_two_bytes;
  logic [15:0] rx_data;
  logic        rx_two_bytes, rx_valid, rd_done, busy;

  wire scl_bus = scl_m & scl_out;
  wire sda_bus = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_target #(
    .TARGET_ADDR(Addr),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl_bus),
    .sda_in      (sda_bus),
    .sda_out     (sda_out),
    .scl_out     (scl_out),
    .tx_data     (tx_data),
    .tx_two_bytes(tx_two_bytes),
    .rx_data     (rx_data),
    .rx_two_bytes(rx_two_bytes),
    .rx_valid    (rx_valid),
    .rd_done     (rd_done),
    .busy        (busy)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          sda_low_cnt = 0;
  exp_t        exp_q[$];
  logic [15:0] rx_model = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period of 16 clk: data set mid-low, sampled mid-high.
  task automatic bus_bit(input bit b, output bit r);
    wait_clk(4); sda_m = b;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(4); r = sda_bus;
    wait_clk(4); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(4); sda_m = 1'b0;
    wait_clk(4); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(4); sda_m = 1'b0;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] b);
    bit r;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      b = {b[6:0], r};
    end
    bus_bit(ack, r);
  endtask

  // Write of n bytes (data packed MSB-first); send_stop=0 leaves the bus for a repeated START.
  task automatic do_write(input logic [6:0] addr, input int n, input logic [23:0] data,
                          input bit send_stop);
    bit          match, ack;
    logic [15:0] acc;
    int          low0;
    exp_t        e;
    match = (addr == Addr);
    acc   = rx_model;
    for (int i = 0; i < n && i < 2; i++) acc = {acc[7:0], data[23-8*i -: 8]};
    if (match) begin
      rx_model = acc;
      if (send_stop && n > 0) begin
        e.is_write = 1'b1; e.data = acc; e.two = (n >= 2);
        exp_q.push_back(e);
      end
    end
    low0 = sda_low_cnt;
    i2c_start();
    send_byte({addr, 1'b0}, ack);
    check("wr_addr_ack", ack, !match);
    check("wr_busy", busy, match);
    for (int i = 0; i < n; i++) begin
      send_byte(data[23-8*i -: 8], ack);
      check("wr_data_ack", ack, !(match && i < 2));
    end
    if (!match) check("nomatch_sda_low_cycles", sda_low_cnt - low0, 0);
    if (send_stop) i2c_stop();
  endtask

  // Read of n bytes; master ACKs all but the last. tx_data is scrambled after the address ACK.
  task automatic do_read(input logic [6:0] addr, input int n);
    bit          match, ack;
    logic [23:0] stream;
    logic [7:0]  got;
    exp_t        e;
    match  = (addr == Addr);
    stream = tx_two_bytes ? {tx_data, 8'hFF} : {tx_data[7:0], 16'hFFFF};
    if (match) begin
      e.is_write = 1'b0; e.data = 16'h0; e.two = 1'b0;
      exp_q.push_back(e);
    end
    i2c_start();
    send_byte({addr, 1'b1}, ack);
    check("rd_addr_ack", ack, !match);
    check("rd_busy", busy, match);
    tx_data      = 16'($urandom);
    tx_two_bytes = 1'($urandom);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, got);
        check("rd_data", got, stream[23-8*i -: 8]);
      end
      check("rd_sda_released", sda_out, 1'b1);
    end
    i2c_stop();
  endtask

  // Scoreboard monitor: pops one expectation per rx_valid / rd_done pulse.
  initial begin
    exp_t e;
    bit   prev_rxv = 1'b0;
    bit   prev_rdd = 1'b0;
    forever begin
      @(negedge clk);
      if (!sda_out) sda_low_cnt++;
      if (rx_valid || rd_done) begin
        if (rx_valid) check("rx_valid_width", prev_rxv, 1'b0);
        if (rd_done)  check("rd_done_width", prev_rdd, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: rx_valid=%0b rd_done=%0b, required none", rx_valid,
                   rd_done);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", rx_valid, e.is_write);
          if (e.is_write) begin
            check("rx_data", rx_data, e.data);
            check("rx_two_bytes", rx_two_bytes, e.two);
          end
        end
      end
      prev_rxv = rx_valid;
      prev_rdd = rd_done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    bit         found;
    bit         r;
    int         sel, n;
    logic [6:0] a;
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tx_data = 16'h0; tx_two_bytes = 1'b0;
    wait_clk(5);
    check("reset_sda_out", sda_out, 1'b1);
    check("reset_scl_out", scl_out, 1'b1);
    check("reset_rx_data", rx_data, 16'h0);
    check("reset_outputs", {rx_two_bytes, rx_valid, rd_done, busy}, 4'b0000);
    rst = 1'b1;
    wait_clk(20);

    do_write(Addr, 1, 24'hA50000, 1'b1);
    do_write(Addr, 2, 24'h123400, 1'b1);
    tx_data = 16'hBEEF; tx_two_bytes = 1'b1;
    do_read(Addr, 2);
    do_write(7'h43, 2, 24'h5A5A00, 1'b1);
    tx_data = 16'hC3D4; tx_two_bytes = 1'b0;
    do_write(Addr, 0, 24'h0, 1'b0);
    do_read(Addr, 1);
    do_write(Addr, 3, 24'hDEADBE, 1'b1);

    // Reset while the target holds the address ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) bus_bit(i == 0 ? 1'b0 : Addr[i-1], r);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      wait_clk(1);
      if (!sda_out) found = 1'b1;
    end
    check("ack_driven_before_reset", found, 1'b1);
    rst = 1'b0;
    wait_clk(1);
    check("midreset_sda_out", sda_out, 1'b1);
    check("midreset_rx_data", rx_data, 16'h0);
    check("midreset_outputs", {rx_two_bytes, rx_valid, rd_done, busy}, 4'b0000);
    rst = 1'b1;
    rx_model = 16'h0;
    bus_bit(1'b1, r);
    i2c_stop();
    do_write(Addr, 1, 24'h3C0000, 1'b1);

    for (int t = 0; t < 14; t++) begin
      sel = int'($urandom_range(0, 3));
      a   = (sel < 2) ? Addr : (sel == 2) ? 7'h43 : 7'($urandom);
      n   = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, n, 24'($urandom), 1'b1);
      end else begin
        tx_data = 16'($urandom); tx_two_bytes = 1'($urandom);
        do_read(a, n);
      end
      wait_clk(8);
    end

    wait_clk(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
